sum_ascii_sequencer: RTL and testbench

//   Downstream formatter between the adder result and the UART transmitter.
//   On a start pulse it captures the binary sum and converts it to decimal
//   (double-dabble, one bit per cycle). It then hands the UART one byte at a

---
 rtl/sum_ascii_sequencer.sv | 147 ++++++++++++++
 tb/tb_sum_ascii_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_ascii_sequencer.sv
// Converts a captured binary sum to decimal ASCII using double-dabble and
// hands the digits, plus an optional CR LF, to a UART one byte at a time.
module sum_ascii_sequencer #(
   parameter int SUM_W      = 5,
   parameter int NUM_DIGITS = 2,
   parameter int SEND_CRLF  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [SUM_W-1:0] sum_in,
   input  logic             tx_busy,
   output logic             tx_en,
   output logic [7:0]       tx_data,
   output logic             busy,
   output logic             done
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int NB    = NUM_DIGITS + 2 * SEND_CRLF;
   localparam int K_W   = $clog2(NB + 1);
   localparam int C_W   = $clog2(SUM_W + 1);

   localparam logic [K_W-1:0] LP_K_LAST = K_W'(NB - 1);
   localparam logic [K_W-1:0] LP_K_ND   = K_W'(NUM_DIGITS);
   localparam logic [C_W-1:0] LP_C_INIT = C_W'(SUM_W);
   localparam logic [C_W-1:0] LP_C_ONE  = C_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONV,
      S_LOAD,
      S_SEND,
      S_ACK,
      S_DRAIN
   } t_state;

   t_state             r_state;
   logic [SUM_W-1:0]   r_sum;
   logic [BCD_W-1:0]   r_bcd;
   logic [C_W-1:0]     r_cnt;
   logic [K_W-1:0]     r_k;

   logic [BCD_W-1:0]   w_bcd_adj;
   logic [BCD_W-1:0]   w_bcd_next;
   logic [7:0]         w_byte;

   // Double-dabble correction: every nibble of 5 or more gets +3 before the shift.
   function automatic logic [BCD_W-1:0] f_add3(input logic [BCD_W-1:0] bcd);
      logic [BCD_W-1:0] res;
      res = bcd;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5)
            res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
      return res;
   endfunction

   function automatic logic [7:0] f_ascii(input logic [K_W-1:0] k,
                                          input logic [BCD_W-1:0] bcd);
      logic [3:0] dig;
      logic [7:0] res;
      dig = 4'd0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (k == K_W'(d))
            dig = bcd[4*(NUM_DIGITS-1-d) +: 4];
      end
      if (k < LP_K_ND)
         res = 8'h30 | {4'h0, dig};
      else if (k == LP_K_ND)
         res = 8'h0D;
      else
         res = 8'h0A;
      return res;
   endfunction

   always_comb begin
      w_bcd_adj  = f_add3(r_bcd);
      w_bcd_next = (w_bcd_adj << 1) | {{(BCD_W-1){1'b0}}, r_sum[SUM_W-1]};
      w_byte     = f_ascii(r_k, r_bcd);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_sum   <= '0;
         r_bcd   <= '0;
         r_cnt   <= '0;
         r_k     <= '0;
         tx_en   <= 1'b0;
         tx_data <= 8'h00;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_sum   <= sum_in;
                  r_bcd   <= '0;
                  r_cnt   <= LP_C_INIT;
                  busy    <= 1'b1;
                  r_state <= S_CONV;
               end
            end
            S_CONV: begin
               r_bcd <= w_bcd_next;
               r_sum <= r_sum << 1;
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == LP_C_ONE)
                  r_state <= S_LOAD;
            end
            S_LOAD: begin
               r_k     <= '0;
               r_state <= S_SEND;
            end
            S_SEND: begin
               if (!tx_busy) begin
                  tx_en   <= 1'b1;
                  tx_data <= w_byte;
                  r_state <= S_ACK;
               end
            end
            // Handshake: wait for the UART to take the byte, then to finish it.
            S_ACK: begin
               tx_en <= 1'b0;
               if (tx_busy)
                  r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (!tx_busy) begin
                  if (r_k == LP_K_LAST) begin
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     r_state <= S_IDLE;
                  end else begin
                     r_k     <= r_k + 1'b1;
                     r_state <= S_SEND;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sum_ascii_sequencer.sv
// Bench for sum_ascii_sequencer: UART model, byte monitor and decimal reference.
`timescale 1ns/1ps
module tb_sum_ascii_sequencer;

   localparam int SUM_W = 5;
   localparam int ND    = 2;
   localparam int NB_A  = ND + 2;
   localparam int NB_B  = ND;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             st_a = 1'b0, st_b = 1'b0;
   logic [SUM_W-1:0] sum_a = '0, sum_b = '0;
   logic             tx_busy_a, tx_busy_b;
   logic             tx_en_a, tx_en_b;
   logic [7:0]       tx_data_a, tx_data_b;
   logic             busy_a, busy_b, done_a, done_b;

   int n_chk = 0;
   int n_fail = 0;

   logic [7:0] q_a[$];
   logic [7:0] q_b[$];
   int done_a_cnt = 0, done_b_cnt = 0;
   int dbl_a = 0, dbl_b = 0;
   int cnt_a = 0, cnt_b = 0;
   logic hold_a = 1'b0;
   logic prev_a = 1'b0, prev_b = 1'b0;

   always #5 clk = ~clk;

   assign tx_busy_a = (cnt_a != 0) || hold_a;
   assign tx_busy_b = (cnt_b != 0);

   sum_ascii_sequencer #(.SUM_W(SUM_W), .NUM_DIGITS(ND), .SEND_CRLF(1)) dut_a (
      .clk(clk), .reset(reset), .start(st_a), .sum_in(sum_a), .tx_busy(tx_busy_a),
      .tx_en(tx_en_a), .tx_data(tx_data_a), .busy(busy_a), .done(done_a));

   sum_ascii_sequencer #(.SUM_W(SUM_W), .NUM_DIGITS(ND), .SEND_CRLF(0)) dut_b (
      .clk(clk), .reset(reset), .start(st_b), .sum_in(sum_b), .tx_busy(tx_busy_b),
      .tx_en(tx_en_b), .tx_data(tx_data_b), .busy(busy_b), .done(done_b));

   // Byte monitor and UART model: busy rises half a cycle after tx_en, held 10 cycles.
   always @(negedge clk) begin
      if (tx_en_a) q_a.push_back(tx_data_a);
      if (tx_en_a && prev_a) dbl_a++;
      prev_a = tx_en_a;
      if (done_a) done_a_cnt++;
      if (reset) cnt_a = 0;
      else if (tx_en_a) cnt_a = 10;
      else if (cnt_a > 0) cnt_a--;

      if (tx_en_b) q_b.push_back(tx_data_b);
      if (tx_en_b && prev_b) dbl_b++;
      prev_b = tx_en_b;
      if (done_b) done_b_cnt++;
      if (reset) cnt_b = 0;
      else if (tx_en_b) cnt_b = 10;
      else if (cnt_b > 0) cnt_b--;
   end

   function automatic logic [7:0] exp_byte(input int v, input int k);
      int p;
      p = 1;
      if (k < ND) begin
         for (int i = 0; i < ND - 1 - k; i++) p = p * 10;
         return 8'h30 + 8'((v / p) % 10);
      end else if (k == ND) begin
         return 8'h0D;
      end
      return 8'h0A;
   endfunction

   task automatic start_line_a(input int v);
      @(posedge clk); #1;
      sum_a = SUM_W'(v);
      st_a  = 1'b1;
      @(posedge clk); #1;
      st_a  = 1'b0;
   endtask

   task automatic wait_done_a(input int target, output bit to);
      int n;
      n  = 0;
      to = 1'b0;
      while (done_a_cnt < target && n < 1000) begin
         @(posedge clk);
         n++;
      end
      if (done_a_cnt < target) to = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      @(posedge clk); #1;
      n_chk++; if (tx_en_a !== 1'b0) begin n_fail++; $display("FAIL reset_tx_en got %b want 0", tx_en_a); end
      n_chk++; if (tx_data_a !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h want 00", tx_data_a); end
      n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_a); end
      n_chk++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done_a); end
      n_chk++; if ({tx_en_b, busy_b, done_b, tx_data_b} !== 11'd0) begin
         n_fail++; $display("FAIL reset_b got %b want 0", {tx_en_b, busy_b, done_b, tx_data_b});
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_line(input int v, input string tag);
      int n;
      int d0;
      int e0;
      bit to;
      q_a.delete();
      d0 = done_a_cnt;
      e0 = dbl_a;
      start_line_a(v);
      n_chk++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL %s busy_after_start got %b want 1", tag, busy_a); end
      n = 0;
      while (tx_en_a !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      n_chk++; if (n != SUM_W + 2) begin n_fail++; $display("FAIL %s first_byte_latency got %0d want %0d", tag, n, SUM_W + 2); end
      wait_done_a(d0 + 1, to);
      n_chk++; if (to) begin n_fail++; $display("FAIL %s done_timeout got none want 1 pulse", tag); end
      n_chk++; if (q_a.size() != NB_A) begin n_fail++; $display("FAIL %s byte_count got %0d want %0d", tag, q_a.size(), NB_A); end
      for (int k = 0; k < NB_A; k++) begin
         if (k < q_a.size()) begin
            n_chk++;
            if (q_a[k] !== exp_byte(v, k)) begin
               n_fail++; $display("FAIL %s byte%0d (v=%0d) got %h want %h", tag, k, v, q_a[k], exp_byte(v, k));
            end
         end
      end
      n_chk++; if (done_a_cnt != d0 + 1) begin n_fail++; $display("FAIL %s done_pulses got %0d want 1", tag, done_a_cnt - d0); end
      n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL %s busy_after_done got %b want 0", tag, busy_a); end
      n_chk++; if (dbl_a != e0) begin n_fail++; $display("FAIL %s tx_en_width got %0d long pulses want 0", tag, dbl_a - e0); end
   endtask

   task automatic test_random;
      int v;
      for (int i = 0; i < 6; i++) begin
         v = $urandom_range(0, (1 << SUM_W) - 1);
         test_line(v, "random");
      end
   endtask

   task automatic test_no_crlf(input int v);
      int n;
      int d0;
      int e0;
      q_b.delete();
      d0 = done_b_cnt;
      e0 = dbl_b;
      @(posedge clk); #1;
      sum_b = SUM_W'(v);
      st_b  = 1'b1;
      @(posedge clk); #1;
      st_b  = 1'b0;
      n = 0;
      while (done_b_cnt == d0 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      repeat (20) @(posedge clk);
      #1;
      n_chk++; if (q_b.size() != NB_B) begin n_fail++; $display("FAIL nocrlf byte_count got %0d want %0d", q_b.size(), NB_B); end
      for (int k = 0; k < NB_B; k++) begin
         if (k < q_b.size()) begin
            n_chk++;
            if (q_b[k] !== exp_byte(v, k)) begin
               n_fail++; $display("FAIL nocrlf byte%0d (v=%0d) got %h want %h", k, v, q_b[k], exp_byte(v, k));
            end
         end
      end
      n_chk++; if (done_b_cnt != d0 + 1) begin n_fail++; $display("FAIL nocrlf done_pulses got %0d want 1", done_b_cnt - d0); end
      n_chk++; if (busy_b !== 1'b0 || dbl_b != e0) begin n_fail++; $display("FAIL nocrlf busy/pulse got %b/%0d want 0/0", busy_b, dbl_b - e0); end
   endtask

   task automatic test_restart_ignored(input int v);
      int n;
      int d0;
      bit to;
      q_a.delete();
      d0 = done_a_cnt;
      start_line_a(v);
      n = 0;
      while (q_a.size() < 1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
      sum_a = SUM_W'(5);
      st_a  = 1'b1;
      @(posedge clk); #1;
      st_a  = 1'b0;
      wait_done_a(d0 + 1, to);
      repeat (40) @(posedge clk);
      #1;
      n_chk++; if (to) begin n_fail++; $display("FAIL restart done_timeout got none want 1 pulse"); end
      n_chk++; if (q_a.size() != NB_A) begin n_fail++; $display("FAIL restart byte_count got %0d want %0d", q_a.size(), NB_A); end
      for (int k = 0; k < NB_A; k++) begin
         if (k < q_a.size()) begin
            n_chk++;
            if (q_a[k] !== exp_byte(v, k)) begin
               n_fail++; $display("FAIL restart byte%0d got %h want %h", k, q_a[k], exp_byte(v, k));
            end
         end
      end
      n_chk++; if (done_a_cnt != d0 + 1) begin n_fail++; $display("FAIL restart done_pulses got %0d want 1", done_a_cnt - d0); end
      n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL restart busy_idle got %b want 0", busy_a); end
   endtask

   task automatic test_busy_hold(input int v);
      int seen;
      int d0;
      bit to;
      q_a.delete();
      d0 = done_a_cnt;
      hold_a = 1'b1;
      start_line_a(v);
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (tx_en_a) seen++;
      end
      n_chk++; if (seen != 0) begin n_fail++; $display("FAIL busyhold tx_en_while_busy got %0d want 0", seen); end
      n_chk++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL busyhold busy got %b want 1", busy_a); end
      hold_a = 1'b0;
      wait_done_a(d0 + 1, to);
      n_chk++; if (to || q_a.size() != NB_A) begin n_fail++; $display("FAIL busyhold byte_count got %0d want %0d", q_a.size(), NB_A); end
      for (int k = 0; k < NB_A; k++) begin
         if (k < q_a.size()) begin
            n_chk++;
            if (q_a[k] !== exp_byte(v, k)) begin
               n_fail++; $display("FAIL busyhold byte%0d got %h want %h", k, q_a[k], exp_byte(v, k));
            end
         end
      end
   endtask

   task automatic test_reset_mid(input int v);
      int n;
      q_a.delete();
      start_line_a(v);
      n = 0;
      while (q_a.size() < 2 && n < 400) begin
         @(negedge clk);
         n++;
      end
      n_chk++; if (q_a.size() < 2) begin n_fail++; $display("FAIL rstmid second_byte got %0d bytes want 2", q_a.size()); end
      #1;
      reset = 1'b1;
      #1;
      n_chk++; if (tx_en_a !== 1'b0) begin n_fail++; $display("FAIL rstmid tx_en got %b want 0", tx_en_a); end
      n_chk++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin n_fail++; $display("FAIL rstmid busy/done got %b/%b want 0/0", busy_a, done_a); end
      n_chk++; if (tx_data_a !== 8'h00) begin n_fail++; $display("FAIL rstmid tx_data got %h want 00", tx_data_a); end
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if (q_a.size() != 2) begin n_fail++; $display("FAIL rstmid replay got %0d bytes want 2", q_a.size()); end
      test_line(17, "after_reset");
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_line(23, "basic23");
      test_line(0, "zero");
      test_line(31, "max31");
      test_random;
      test_no_crlf(9);
      for (int i = 0; i < 3; i++) test_no_crlf($urandom_range(0, 31));
      test_restart_ignored(23);
      test_busy_hold(14);
      test_reset_mid(28);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
